// File: rtl/dpwm_pi_comp_if.sv
// ---------------------------------------------------------------------------
// dpwm_pi_comp_if
// Bundles the sample/result signals of the DPWM PI compensator.
//   enable       : compensator run (low = loop open)
//   i_vref       : reference code, unsigned, ADC_W bits
//   i_vadc       : ADC sample, unsigned, ADC_W bits
//   i_adc_valid  : one-cycle strobe, i_vadc valid
//   o_ton        : 11-bit on-time word to the DPWM
//   o_ton_valid  : one-cycle pulse when o_ton updates
//   o_busy       : high while a sample is being processed
//   o_overrun    : one-cycle pulse when a sample was dropped
// master = sample producer / result consumer, slave = compensator.
// ---------------------------------------------------------------------------
interface dpwm_pi_comp_if #(
  parameter int ADC_W = 12
);
  logic             enable;
  logic [ADC_W-1:0] i_vref;
  logic [ADC_W-1:0] i_vadc;
  logic             i_adc_valid;
  logic [10:0]      o_ton;
  logic             o_ton_valid;
  logic             o_busy;
  logic             o_overrun;

  modport master (
    output enable, i_vref, i_vadc, i_adc_valid,
    input  o_ton, o_ton_valid, o_busy, o_overrun
  );

  modport slave (
    input  enable, i_vref, i_vadc, i_adc_valid,
    output o_ton, o_ton_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/dpwm_pi_comp.sv
// ---------------------------------------------------------------------------
// dpwm_pi_comp
// Incremental digital PI compensator feeding a DPWM on-time word.
//   acc += KP*(e - e_prev) + KI*e, acc saturated to the on-time window
//   (the saturation doubles as anti-windup), o_ton = acc >> FRAC_BITS.
// One multiplier is time-shared between the P and I products by a
// six-state FSM; a result appears 5 edges after the capture edge.
//
// Ports:
//   i_clk  : system clock (DPWM domain)
//   reset  : asynchronous, active-low reset
//   bus    : dpwm_pi_comp_if.slave (enable, vref/vadc/valid in,
//            ton/ton_valid/busy/overrun out)
//
// Optional feature: define DPWM_PI_SOFT_START_EN to ramp the effective
// reference by one code per accepted sample from 0 toward i_vref.
// Without it the reference is simply i_vref captured with the sample.
// ---------------------------------------------------------------------------
module dpwm_pi_comp #(
  parameter int                 ADC_W     = 12,
  parameter logic signed [15:0] KP        = 16'sd256,
  parameter logic signed [15:0] KI        = 16'sd32,
  parameter int                 FRAC_BITS = 8,
  parameter int                 TON_MAX   = 900,
  parameter int                 TON_MIN   = 0
) (
  input logic           i_clk,
  input logic           reset,
  dpwm_pi_comp_if.slave bus
);

  localparam int EW = ADC_W + 2;
  localparam logic signed [33:0] ACC_HI = 34'(TON_MAX * (2 ** FRAC_BITS));
  localparam logic signed [33:0] ACC_LO = 34'(TON_MIN * (2 ** FRAC_BITS));

  typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, SUM, UPD} state_t;

  state_t                  state_reg, state_next;
  logic [ADC_W-1:0]        vadc_reg;
  logic [ADC_W-1:0]        vref_eff_reg;
  logic signed [EW-1:0]    e_reg, de_reg, e_prev_reg;
  logic signed [31:0]      p_reg, i_reg;
  logic signed [23:0]      acc_reg;
  logic [10:0]             ton_reg;
  logic                    ton_valid_reg;
  logic                    overrun_reg;

  logic                    capture;
  logic                    drop;
  logic signed [EW-1:0]    e_calc, de_calc;
  logic signed [15:0]      mul_a;
  logic signed [EW-1:0]    mul_b;
  logic signed [31:0]      mul_prod;
  logic signed [33:0]      acc_sum;
  logic signed [23:0]      acc_sat;

  assign capture = bus.enable && bus.i_adc_valid && (state_reg == IDLE);
  assign drop    = bus.enable && bus.i_adc_valid && (state_reg != IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!bus.enable) begin
      state_next = IDLE;  // opening the loop aborts any computation
    end else begin
      case (state_reg)
        IDLE:    if (bus.i_adc_valid) state_next = ERR;
        ERR:     state_next = MUL_P;
        MUL_P:   state_next = MUL_I;
        MUL_I:   state_next = SUM;
        SUM:     state_next = UPD;
        UPD:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- effective reference ----------------
`ifdef DPWM_PI_SOFT_START_EN
  // Ramp register: moves one code toward i_vref per accepted sample.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      vref_eff_reg <= '0;
    end else if (!bus.enable) begin
      vref_eff_reg <= '0;
    end else if (capture) begin
      if (vref_eff_reg < bus.i_vref)      vref_eff_reg <= vref_eff_reg + ADC_W'(1);
      else if (vref_eff_reg > bus.i_vref) vref_eff_reg <= vref_eff_reg - ADC_W'(1);
    end
  end
`else
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset)       vref_eff_reg <= '0;
    else if (capture) vref_eff_reg <= bus.i_vref;
  end
`endif

  // ---------------- arithmetic ----------------
  // Zero-extend the unsigned codes so the difference is a proper signed value.
  assign e_calc  = $signed({2'b00, vref_eff_reg}) - $signed({2'b00, vadc_reg});
  assign de_calc = e_calc - e_prev_reg;

  // Shared multiplier: P product in MUL_P, I product otherwise.
  always_comb begin
    mul_a = KI;
    mul_b = e_reg;
    if (state_reg == MUL_P) begin
      mul_a = KP;
      mul_b = de_reg;
    end
  end
  assign mul_prod = 32'(mul_a) * 32'(mul_b);

  // Wide sum cannot overflow; clamping the stored acc is the anti-windup.
  assign acc_sum = 34'(acc_reg) + 34'(p_reg) + 34'(i_reg);

  always_comb begin
    acc_sat = 24'(acc_sum);
    if (acc_sum > ACC_HI)      acc_sat = 24'(ACC_HI);
    else if (acc_sum < ACC_LO) acc_sat = 24'(ACC_LO);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      vadc_reg      <= '0;
      e_reg         <= '0;
      de_reg        <= '0;
      e_prev_reg    <= '0;
      p_reg         <= '0;
      i_reg         <= '0;
      acc_reg       <= '0;
      ton_reg       <= '0;
      ton_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else if (!bus.enable) begin
      acc_reg       <= '0;
      e_prev_reg    <= '0;
      ton_reg       <= '0;
      ton_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      ton_valid_reg <= 1'b0;
      overrun_reg   <= drop;
      case (state_reg)
        IDLE:  if (bus.i_adc_valid) vadc_reg <= bus.i_vadc;
        ERR: begin
          e_reg  <= e_calc;
          de_reg <= de_calc;
        end
        MUL_P: p_reg   <= mul_prod;
        MUL_I: i_reg   <= mul_prod;
        SUM:   acc_reg <= acc_sat;
        UPD: begin
          // acc is never negative after clamping, so this truncates toward zero.
          ton_reg       <= 11'(acc_reg >>> FRAC_BITS);
          ton_valid_reg <= 1'b1;
          e_prev_reg    <= e_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ton       = ton_reg;
  assign bus.o_ton_valid = ton_valid_reg;
  assign bus.o_busy      = (state_reg != IDLE);
  assign bus.o_overrun   = overrun_reg;

endmodule

// File: doc/dpwm_pi_comp.md
Name: dpwm_pi_comp

Overview:
- Digital PI compensator that sits directly upstream of the DPWM stage.
- Takes each ADC output-voltage sample, compares it with a reference, and runs an incremental PI law.
- Produces the 11-bit on-time word that the DPWM latches at its period boundary.
- Uses one time-shared multiplier, sequenced by a small FSM, with output clamping and anti-windup.

Parameters:
- ADC_W, 12, width of ADC sample and reference (unsigned).
- KP, 16'sd256, proportional gain, signed Q7.8 (256 = 1.0).
- KI, 16'sd32, integral gain, signed Q7.8.
- FRAC_BITS, 8, fractional bits of gains and accumulator.
- TON_MAX, 900, upper clamp on o_ton, in DPWM clock counts (period 1000 minus deadtime margin).
- TON_MIN, 0, lower clamp on o_ton.

Ports:
- i_clk  input  1  system clock (same domain as DPWM).
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  compensator run; low = loop open.
- i_vref  input  ADC_W  reference code, unsigned.
- i_vadc  input  ADC_W  ADC sample, unsigned.
- i_adc_valid  input  1  one-cycle strobe, i_vadc valid.
- o_ton  output  11  on-time word to DPWM i_ton.
- o_ton_valid  output  1  one-cycle pulse when o_ton updates.
- o_busy  output  1  high while FSM is not IDLE.
- o_overrun  output  1  one-cycle pulse when a sample is dropped.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, acc=0, e_prev=0, o_ton=0, o_ton_valid=0, o_busy=0, o_overrun=0.
- Error arithmetic:
  - e = vref_eff - vadc, signed ADC_W+2 bits.
  - de = e - e_prev, signed ADC_W+2 bits.
- Products: p = KP*de and i = KI*e, signed 32-bit. One multiplier, used in successive states.
- Accumulator:
  - acc_next = acc + p + i, computed in 34-bit signed.
  - Saturated to [TON_MIN<<FRAC_BITS, TON_MAX<<FRAC_BITS] and stored in a 24-bit signed acc.
  - Saturating acc itself is the anti-windup.
- Output: o_ton = acc >> FRAC_BITS, truncated toward zero. Always in range TON_MIN..TON_MAX.
- FSM:
  - IDLE: if enable and i_adc_valid, latch i_vadc and vref_eff, go to ERR.
  - ERR: register e and de, go to MUL_P.
  - MUL_P: register p, go to MUL_I.
  - MUL_I: register i, go to SUM.
  - SUM: register acc_next (saturated) into acc, go to UPD.
  - UPD: load o_ton from acc, pulse o_ton_valid, e_prev <= e, go to IDLE.
- Latency: o_ton/o_ton_valid change exactly 5 clock edges after the capture edge. One sample is accepted per 6 cycles at most.
- o_busy = (state != IDLE).
- Sample arriving while busy:
  - i_adc_valid while state != IDLE: sample dropped, o_overrun pulses on the next cycle.
  - In-flight computation is unaffected.
- o_ton is held stable between UPD pulses. The DPWM samples it only at its own period end, so no glitch-free handoff beyond this is required.
- enable=0:
  - Synchronously forces state=IDLE, acc=0, e_prev=0, o_ton=0, and ignores samples. An in-flight computation is aborted.
  - Coming back to enable=1 starts from zero state.
- Reset asserted mid-computation: all registers return to reset values immediately (asynchronous).
- i_vref may change at any time; it is sampled only at the capture edge.

Optional Feature:
- Macro: DPWM_PI_SOFT_START_EN.
- With the macro:
  - vref_eff is an internal register, reset/disabled to 0.
  - At each accepted sample, vref_eff increments by 1 if below i_vref, decrements by 1 if above, and otherwise is unchanged.
  - This ramps the loop reference at one code per sample.
- Without the macro: vref_eff = i_vref captured at the capture edge, with no ramp register.

Test Plan:
- Reset and idle: reset=0 then released, no samples → o_ton=0, o_ton_valid=0, o_busy=0 indefinitely.
- Integral step (KP=0, KI=256, no soft start): vref=100, vadc=90, three samples 10 cycles apart → o_ton=10, 20, 30. Each o_ton_valid arrives 5 edges after its capture.
- Proportional increment (KP=256, KI=0): vadc=100 then 90 repeatedly with vref=100 → o_ton=0, then 10, then stays 10.
- Clamp and anti-windup (KP=0, KI=256): vref=4000, vadc=0 → o_ton=900. Then vadc=4095 (e=-95) → o_ton=805, not a wound-up value.
- Overrun: second i_adc_valid 2 cycles after the first → o_overrun pulses once, exactly one o_ton_valid results, and o_ton reflects only the first sample.
- Abort: enable=0 or reset=0 asserted during MUL_I → o_ton=0, o_busy=0. After re-enable, the first result matches fresh-start expectations (e.g. 10 for the integral-step case).
